// File: rtl/ls_pkg.sv
// Shared types for the load/store unit: store-queue entry layout and control states.
package ls_pkg;

    localparam int AW = 8;
    localparam int DW = 8;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } sq_entry_t;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } ctl_state_t;

endpackage

// File: rtl/ls_store_queue.sv
// In-order circular store queue with a parallel youngest-match lookup for load forwarding.
module ls_store_queue #(
    parameter int QDEPTH = 2,
    parameter int AW     = 8,
    parameter int DW     = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        push,
    input  logic [AW-1:0]               push_addr,
    input  logic [DW-1:0]               push_data,
    input  logic                        pop,
    output logic [AW-1:0]               head_addr,
    output logic [DW-1:0]               head_data,
    output logic                        full,
    output logic                        empty,
    output logic [$clog2(QDEPTH):0]     count,
    input  logic [AW-1:0]               lookup_addr,
    output logic                        hit,
    output logic [DW-1:0]               hit_data
);
    import ls_pkg::*;

    localparam int PW = $clog2(QDEPTH);

    sq_entry_t     entries [QDEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [PW:0]   cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else begin
            if (push) tail <= tail + PW'(1);
            if (pop)  head <= head + PW'(1);
            case ({push, pop})
                2'b10:   cnt <= cnt + (PW+1)'(1);
                2'b01:   cnt <= cnt - (PW+1)'(1);
                default: ;
            endcase
        end
    end

    // Payload storage carries no reset; occupancy alone decides validity.
    always_ff @(posedge clk) begin
        if (push) entries[tail] <= '{addr: push_addr, data: push_data};
    end

    // Scan oldest to youngest so the youngest matching entry wins.
    always_comb begin
        logic [PW-1:0] idx;
        hit      = 1'b0;
        hit_data = '0;
        idx      = '0;
        for (int i = 0; i < QDEPTH; i++) begin
            idx = head + PW'(i);
            if (((PW+1)'(i) < cnt) && (entries[idx].addr == lookup_addr)) begin
                hit      = 1'b1;
                hit_data = entries[idx].data;
            end
        end
    end

    assign head_addr = entries[head].addr;
    assign head_data = entries[head].data;
    assign full      = (cnt == (PW+1)'(QDEPTH));
    assign empty     = (cnt == '0);
    assign count     = cnt;

endmodule

// File: rtl/ls_unit.sv
// Load/store unit: store-queue buffering, single memory-port arbitration, fence FSM
// and a registered load-response port.
module ls_unit #(
    parameter int QDEPTH = 2,
    parameter int AW     = 8,
    parameter int DW     = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    input  logic          req_we,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          req_ready,
    output logic          rsp_valid,
    output logic [DW-1:0] rsp_data,
    input  logic          drain,
    output logic          sq_empty,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rdata
);
    import ls_pkg::*;

    localparam int PW = $clog2(QDEPTH);

    ctl_state_t    state;
    logic          sq_full;
    logic          sq_empty_w;
    logic [PW:0]   sq_count;
    logic [AW-1:0] head_addr;
    logic [DW-1:0] head_data;
    logic          sq_hit;
    logic [DW-1:0] sq_hit_data;
    logic          store_acc;
    logic          load_acc;
    logic          port_load;
    logic          sq_pop;
    logic          rsp_vld_p1;
    logic [DW-1:0] rsp_data_p1;

    ls_store_queue #(
        .QDEPTH (QDEPTH),
        .AW     (AW),
        .DW     (DW)
    ) u_sq (
        .clk         (clk),
        .rst_n       (rst_n),
        .push        (store_acc),
        .push_addr   (req_addr),
        .push_data   (req_wdata),
        .pop         (sq_pop),
        .head_addr   (head_addr),
        .head_data   (head_data),
        .full        (sq_full),
        .empty       (sq_empty_w),
        .count       (sq_count),
        .lookup_addr (req_addr),
        .hit         (sq_hit),
        .hit_data    (sq_hit_data)
    );

    assign req_ready = (state == RUN) && !sq_full;
    assign store_acc = req_valid && req_ready && req_we;
    assign load_acc  = req_valid && req_ready && !req_we;
    // A forwarded load leaves the port free, so the head may drain alongside it.
    assign port_load = load_acc && !sq_hit;
    assign sq_pop    = !sq_empty_w && !port_load;
    assign sq_empty  = sq_empty_w;

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (port_load) begin
            mem_addr = req_addr;
        end else if (sq_pop) begin
            mem_we    = 1'b1;
            mem_addr  = head_addr;
            mem_wdata = head_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            case (state)
                RUN:     if (drain) state <= FLUSH;
                FLUSH:   if (!drain && (sq_count == '0)) state <= RUN;
                default: state <= RUN;
            endcase
        end
    end

    // Stage p1: load response captured at the acceptance edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_vld_p1  <= 1'b0;
            rsp_data_p1 <= '0;
        end else begin
            rsp_vld_p1 <= load_acc;
            if (load_acc) rsp_data_p1 <= sq_hit ? sq_hit_data : mem_rdata;
        end
    end

    assign rsp_valid = rsp_vld_p1;
    assign rsp_data  = rsp_data_p1;

endmodule

// File: tb/tb_ls_unit.sv
// Bench for ls_unit: behavioural queue/memory model checked every cycle, directed
// scenarios with literal expectations, then randomized traffic.
module tb_ls_unit;

    localparam int QD = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_we = 1'b0;
    logic [7:0] req_addr = '0;
    logic [7:0] req_wdata = '0;
    logic       req_ready;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       drain = 1'b0;
    logic       sq_empty;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       mem_we;
    logic [7:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    logic [7:0] tb_mem [256];
    logic [7:0] m_mem  [256];

    typedef struct {
        logic [7:0] a;
        logic [7:0] d;
    } ent_t;

    ent_t       mq[$];
    bit         m_flush = 0;
    logic       e_rv = 1'b0;
    logic [7:0] e_rd = 8'h00;

    ls_unit #(.QDEPTH(QD), .AW(8), .DW(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .drain     (drain),
        .sq_empty  (sq_empty),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = tb_mem[mem_addr];
    always @(posedge clk) if (mem_we) tb_mem[mem_addr] = mem_wdata;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: checked and advanced on every falling edge, inputs being stable there.
    always @(negedge clk) begin
        bit         rdy, acc, ld, fwd, chk_wd, ewe;
        logic [7:0] fd, eaddr, ewd;
        if (!rst_n) begin
            mq.delete();
            m_flush = 0;
            e_rv = 1'b0;
            e_rd = 8'h00;
        end
        rdy = !m_flush && (mq.size() < QD);
        acc = req_valid && rdy;
        ld  = acc && !req_we;
        fwd = 0;
        fd  = 8'h00;
        if (ld) begin
            foreach (mq[i]) if (mq[i].a == req_addr) begin
                fwd = 1;
                fd  = mq[i].d;
            end
        end
        if (ld && !fwd) begin
            ewe = 0; eaddr = req_addr; ewd = 8'h00; chk_wd = 0;
        end else if (mq.size() > 0) begin
            ewe = 1; eaddr = mq[0].a; ewd = mq[0].d; chk_wd = 1;
        end else begin
            ewe = 0; eaddr = 8'h00; ewd = 8'h00; chk_wd = 1;
        end
        chk("rsp_valid", rsp_valid, e_rv);
        chk("rsp_data", rsp_data, e_rd);
        chk("req_ready", req_ready, rdy);
        chk("sq_empty", sq_empty, mq.size() == 0);
        chk("mem_we", mem_we, ewe);
        chk("mem_addr", mem_addr, eaddr);
        if (chk_wd) chk("mem_wdata", mem_wdata, ewd);
        if (rst_n) begin
            e_rv = ld;
            if (ld) e_rd = fwd ? fd : m_mem[req_addr];
            if (m_flush) begin
                if (mq.size() == 0 && !drain) m_flush = 0;
            end else if (drain) begin
                m_flush = 1;
            end
            if (ewe) begin
                m_mem[mq[0].a] = mq[0].d;
                void'(mq.pop_front());
            end
            if (acc && req_we) mq.push_back('{a: req_addr, d: req_wdata});
        end
    end

    task automatic idle(input int n);
        req_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic we, input logic [7:0] a, input logic [7:0] d);
        bit done = 0;
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
        for (int k = 0; k < 20 && !done; k++) begin
            #1;
            done = req_ready;
            @(posedge clk);
            #1;
        end
        chk("send_accepted", done, 1'b1);
        req_valid = 1'b0;
    endtask

    initial begin
        logic [7:0] v;
        logic [7:0] old70;
        int bad;
        for (int i = 0; i < 256; i++) begin
            v = 8'($urandom);
            tb_mem[i] = v;
            m_mem[i]  = v;
        end
        tb_mem[8'h10] = 8'h5A; m_mem[8'h10] = 8'h5A;
        tb_mem[8'h70] = 8'h11; m_mem[8'h70] = 8'h11;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_rsp_valid", rsp_valid, 1'b0);
        chk("reset_rsp_data", rsp_data, 8'h00);
        chk("reset_sq_empty", sq_empty, 1'b1);
        chk("reset_req_ready", req_ready, 1'b1);
        chk("reset_mem_we", mem_we, 1'b0);
        rst_n = 1'b1;
        idle(1);

        // Plain load from preloaded memory
        send(1'b0, 8'h10, 8'h00);
        chk("load_rsp_valid", rsp_valid, 1'b1);
        chk("load_rsp_data", rsp_data, 8'h5A);
        chk("load_mem_we", mem_we, 1'b0);
        idle(1);
        chk("load_rsp_pulse", rsp_valid, 1'b0);

        // Store then immediate load to the same address
        send(1'b1, 8'h20, 8'h33);
        send(1'b0, 8'h20, 8'h00);
        chk("fwd_rsp_data", rsp_data, 8'h33);
        idle(2);
        chk("fwd_mem_20", tb_mem[8'h20], 8'h33);

        // Two stores to one address, youngest forwards
        send(1'b1, 8'h40, 8'h01);
        send(1'b1, 8'h40, 8'h02);
        send(1'b0, 8'h40, 8'h00);
        chk("young_rsp_data", rsp_data, 8'h02);
        idle(3);
        chk("young_mem_40", tb_mem[8'h40], 8'h02);

        // Missing loads hold the port; the pending store waits, then drains
        send(1'b1, 8'h50, 8'h77);
        for (int k = 0; k < 3; k++) send(1'b0, 8'h60 + 8'(k), 8'h00);
        chk("loadprio_sq_empty", sq_empty, 1'b0);
        idle(2);
        chk("loadprio_mem_50", tb_mem[8'h50], 8'h77);

        // Fence
        send(1'b1, 8'h58, 8'h9C);
        drain = 1'b1;
        #1;
        chk("fence_drain_we", mem_we, 1'b1);
        @(posedge clk); #1;
        chk("fence_ready0_a", req_ready, 1'b0);
        chk("fence_empty", sq_empty, 1'b1);
        @(posedge clk); #1;
        chk("fence_ready0_b", req_ready, 1'b0);
        drain = 1'b0;
        #1;
        chk("fence_ready0_c", req_ready, 1'b0);
        @(posedge clk); #1;
        chk("fence_run_ready", req_ready, 1'b1);
        chk("fence_mem_58", tb_mem[8'h58], 8'h9C);

        // Reset during a pending drain
        old70 = tb_mem[8'h70];
        send(1'b1, 8'h70, 8'hEE);
        #1;
        chk("rst_pre_we", mem_we, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_sq_empty", sq_empty, 1'b1);
        chk("rst_req_ready", req_ready, 1'b1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(2);
        chk("rst_mem_70_kept", tb_mem[8'h70], old70);

        // Randomized traffic on a small address window to exercise forwarding
        for (int c = 0; c < 3000; c++) begin
            req_valid = ($urandom_range(0, 9) < 7);
            req_we    = 1'($urandom_range(0, 1));
            req_addr  = 8'h80 + 8'($urandom_range(0, 7));
            req_wdata = 8'($urandom);
            drain     = ($urandom_range(0, 19) == 0);
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        drain = 1'b0;
        idle(6);

        bad = 0;
        for (int i = 0; i < 256; i++) if (tb_mem[i] !== m_mem[i]) bad++;
        chk("mem_image_mismatches", bad, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
